// File: rtl/frame_fifo_read_if.sv
// Memory controller read-burst port shared by the frame reader and the controller.
interface frame_fifo_read_if #(
  parameter int ADDR_BITS  = 23,
  parameter int BURST_BITS = 10
);
  logic                  rd_burst_req;
  logic [BURST_BITS-1:0] rd_burst_len;
  logic [ADDR_BITS-1:0]  rd_burst_addr;
  logic                  rd_burst_data_valid;
  logic                  rd_burst_finish;

  // Frame reader side: issues the burst request.
  modport master (
    output rd_burst_req,
    output rd_burst_len,
    output rd_burst_addr,
    input  rd_burst_data_valid,
    input  rd_burst_finish
  );

  // Memory controller side: serves the burst.
  modport slave (
    input  rd_burst_req,
    input  rd_burst_len,
    input  rd_burst_addr,
    output rd_burst_data_valid,
    output rd_burst_finish
  );
endinterface

// File: rtl/frame_fifo_read.sv
// Frame reader: on request, clears the output FIFO and streams one frame from
// memory into it as a series of bursts, throttled by FIFO free space.
//
// state            | meaning
// -----------------+-------------------------------------------------------
// S_IDLE           | waiting for a frame read request
// S_ACK            | acknowledging request, FIFO clear, latch base and length
// S_CHECK_FIFO     | decide: restart, frame done, issue burst, or wait
// S_READ_BURST     | burst in flight at the memory controller
// S_READ_BURST_END | burst done, check for restart before next burst
// S_END            | one-cycle frame-complete state (drives read_finish)
module frame_fifo_read #(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 23,
  parameter int BURST_BITS    = 10,
  parameter int BURST_SIZE    = 256,
  parameter int FIFO_DEPTH    = 1024
) (
  input  logic                 mem_clk,
  input  logic                 rst,
  frame_fifo_read_if.master    mem_rd,
  input  logic                 read_req,
  output logic                 read_req_ack,
  output logic                 read_finish,
  input  logic [ADDR_BITS-1:0] read_addr_0,
  input  logic [ADDR_BITS-1:0] read_addr_1,
  input  logic [ADDR_BITS-1:0] read_addr_2,
  input  logic [ADDR_BITS-1:0] read_addr_3,
  input  logic [1:0]           read_addr_index,
  input  logic [ADDR_BITS-1:0] read_len,
  output logic                 fifo_aclr,
  input  logic [15:0]          wr_data_count
);

  // Parameter sanity: the burst length field must be able to hold a full burst.
  if (BURST_SIZE >= (1 << BURST_BITS)) begin : g_bad_burst_bits
    $error("BURST_BITS too narrow for BURST_SIZE");
  end
  if (MEM_DATA_BITS < 1) begin : g_bad_data_bits
    $error("MEM_DATA_BITS must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_ACK            = 3'd1,
    S_CHECK_FIFO     = 3'd2,
    S_READ_BURST     = 3'd3,
    S_READ_BURST_END = 3'd4,
    S_END            = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic                  req_d0_q;
  logic [1:0]            idx_d0_q;
  logic [ADDR_BITS-1:0]  len_d0_q;

  logic [ADDR_BITS-1:0]  read_cnt_q, read_cnt_d;
  logic [ADDR_BITS-1:0]  len_latch_q, len_latch_d;
  logic                  rd_burst_req_q, rd_burst_req_d;
  logic [BURST_BITS-1:0] rd_burst_len_q, rd_burst_len_d;
  logic [ADDR_BITS-1:0]  rd_burst_addr_q, rd_burst_addr_d;
  logic                  read_req_ack_q, read_req_ack_d;
  logic                  fifo_aclr_q, fifo_aclr_d;

  logic [ADDR_BITS-1:0]  remain;
  logic [BURST_BITS-1:0] blen;
  logic [16:0]           fifo_need;
  logic                  fifo_fits;
  logic [ADDR_BITS-1:0]  base_sel;
  logic [ADDR_BITS-1:0]  burst_step;

  // Register the request-side inputs once; every decision uses these copies.
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      req_d0_q <= 1'b0;
      idx_d0_q <= 2'd0;
      len_d0_q <= '0;
    end else begin
      req_d0_q <= read_req;
      idx_d0_q <= read_addr_index;
      len_d0_q <= read_len;
    end
  end

  // Burst sizing, FIFO space check and base address selection.
  always_comb begin
    remain = len_latch_q - read_cnt_q;
    if (remain > ADDR_BITS'(BURST_SIZE)) begin
      blen = BURST_BITS'(BURST_SIZE);
    end else begin
      blen = remain[BURST_BITS-1:0];
    end
    // 17 bits so a nearly-full count plus a full burst cannot wrap past the depth.
    fifo_need  = 17'(wr_data_count) + 17'(blen);
    fifo_fits  = (fifo_need <= 17'(FIFO_DEPTH));
    burst_step = ADDR_BITS'(rd_burst_len_q);
    case (idx_d0_q)
      2'd0:    base_sel = read_addr_0;
      2'd1:    base_sel = read_addr_1;
      2'd2:    base_sel = read_addr_2;
      default: base_sel = read_addr_3;
    endcase
  end

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d         = state_q;
    read_cnt_d      = read_cnt_q;
    len_latch_d     = len_latch_q;
    rd_burst_req_d  = rd_burst_req_q;
    rd_burst_len_d  = rd_burst_len_q;
    rd_burst_addr_d = rd_burst_addr_q;
    read_req_ack_d  = read_req_ack_q;
    fifo_aclr_d     = fifo_aclr_q;

    case (state_q)
      S_IDLE: begin
        read_req_ack_d = 1'b0;
        if (req_d0_q) state_d = S_ACK;
      end
      S_ACK: begin
        if (req_d0_q) begin
          read_req_ack_d  = 1'b1;
          fifo_aclr_d     = 1'b1;
          rd_burst_addr_d = base_sel;
          len_latch_d     = len_d0_q;
          read_cnt_d      = '0;
        end else begin
          read_req_ack_d  = 1'b0;
          fifo_aclr_d     = 1'b0;
          state_d         = S_CHECK_FIFO;
        end
      end
      S_CHECK_FIFO: begin
        if (req_d0_q) begin
          state_d = S_ACK;
        end else if (read_cnt_q >= len_latch_q) begin
          state_d = S_END;
        end else if (fifo_fits) begin
          rd_burst_len_d = blen;
          rd_burst_req_d = 1'b1;
          state_d        = S_READ_BURST;
        end
      end
      S_READ_BURST: begin
        // A burst always runs to completion; restart is handled afterwards.
        if (mem_rd.rd_burst_data_valid) rd_burst_req_d = 1'b0;
        if (mem_rd.rd_burst_finish) begin
          read_cnt_d      = read_cnt_q + burst_step;
          rd_burst_addr_d = rd_burst_addr_q + burst_step;
          state_d         = S_READ_BURST_END;
        end
      end
      S_READ_BURST_END: begin
        state_d = req_d0_q ? S_ACK : S_CHECK_FIFO;
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      read_cnt_q      <= '0;
      len_latch_q     <= '0;
      rd_burst_req_q  <= 1'b0;
      rd_burst_len_q  <= '0;
      rd_burst_addr_q <= '0;
      read_req_ack_q  <= 1'b0;
      fifo_aclr_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      read_cnt_q      <= read_cnt_d;
      len_latch_q     <= len_latch_d;
      rd_burst_req_q  <= rd_burst_req_d;
      rd_burst_len_q  <= rd_burst_len_d;
      rd_burst_addr_q <= rd_burst_addr_d;
      read_req_ack_q  <= read_req_ack_d;
      fifo_aclr_q     <= fifo_aclr_d;
    end
  end

  assign mem_rd.rd_burst_req  = rd_burst_req_q;
  assign mem_rd.rd_burst_len  = rd_burst_len_q;
  assign mem_rd.rd_burst_addr = rd_burst_addr_q;
  assign read_req_ack         = read_req_ack_q;
  assign fifo_aclr            = fifo_aclr_q;
  assign read_finish          = (state_q == S_END);

endmodule

// File: tb/tb_frame_fifo_read.sv
// Bench for frame_fifo_read: a memory-controller responder pops expected
// bursts from a scoreboard filled when each frame request is issued.
module tb_frame_fifo_read;
  localparam int ADDR_BITS  = 23;
  localparam int BURST_BITS = 10;
  localparam int BURST_SIZE = 256;
  localparam int FIFO_DEPTH = 1024;

  typedef struct {
    logic [ADDR_BITS-1:0]  addr;
    logic [BURST_BITS-1:0] len;
  } burst_t;

  logic                 mem_clk = 1'b0;
  logic                 rst;
  logic                 read_req;
  logic                 read_req_ack;
  logic                 read_finish;
  logic [ADDR_BITS-1:0] read_addr_0, read_addr_1, read_addr_2, read_addr_3;
  logic [1:0]           read_addr_index;
  logic [ADDR_BITS-1:0] read_len;
  logic                 fifo_aclr;
  logic [15:0]          wr_data_count;

  frame_fifo_read_if #(.ADDR_BITS(ADDR_BITS), .BURST_BITS(BURST_BITS)) mem_rd ();

  frame_fifo_read #(
    .MEM_DATA_BITS(32), .ADDR_BITS(ADDR_BITS), .BURST_BITS(BURST_BITS),
    .BURST_SIZE(BURST_SIZE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .mem_clk         (mem_clk),
    .rst             (rst),
    .mem_rd          (mem_rd),
    .read_req        (read_req),
    .read_req_ack    (read_req_ack),
    .read_finish     (read_finish),
    .read_addr_0     (read_addr_0),
    .read_addr_1     (read_addr_1),
    .read_addr_2     (read_addr_2),
    .read_addr_3     (read_addr_3),
    .read_addr_index (read_addr_index),
    .read_len        (read_len),
    .fifo_aclr       (fifo_aclr),
    .wr_data_count   (wr_data_count)
  );

  always #5 mem_clk = ~mem_clk;

  burst_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_finish = 0;
  int n_req    = 0;
  int n_aclr_bad = 0;
  int served   = 0;
  bit merge_last = 1'b0;

  // Monitor: count finish pulses and request rises, watch aclr/ack pairing.
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge mem_clk);
      if (!rst) begin
        if (read_finish === 1'b1) n_finish++;
        if (mem_rd.rd_burst_req === 1'b1 && prev_req !== 1'b1) n_req++;
        if (fifo_aclr !== read_req_ack) n_aclr_bad++;
        if (fifo_aclr === 1'b1 && mem_rd.rd_burst_req === 1'b1) n_aclr_bad++;
      end
      prev_req = mem_rd.rd_burst_req;
    end
  end

  // Memory controller model: checks each request against the scoreboard and
  // returns the requested number of beats followed by a finish pulse.
  initial begin
    burst_t exp_b;
    int blen;
    mem_rd.rd_burst_data_valid = 1'b0;
    mem_rd.rd_burst_finish     = 1'b0;
    forever begin
      @(negedge mem_clk);
      if (!rst && mem_rd.rd_burst_req === 1'b1) begin
        served++;
        blen = int'(mem_rd.rd_burst_len);
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL burst_unexpected addr=%h len=%0d (no burst expected)",
                   mem_rd.rd_burst_addr, blen);
        end else begin
          exp_b = sb_q.pop_front();
          n_checks++;
          if (mem_rd.rd_burst_addr !== exp_b.addr)
            $display("FAIL burst_addr got=%h exp=%h", mem_rd.rd_burst_addr, exp_b.addr);
          else n_pass++;
          n_checks++;
          if (mem_rd.rd_burst_len !== exp_b.len)
            $display("FAIL burst_len got=%0d exp=%0d", mem_rd.rd_burst_len, exp_b.len);
          else n_pass++;
        end
        repeat (2) @(negedge mem_clk);
        for (int i = 0; i < blen; i++) begin
          mem_rd.rd_burst_data_valid = 1'b1;
          mem_rd.rd_burst_finish     = (merge_last && i == blen - 1);
          @(negedge mem_clk);
          if (i == 0) begin
            n_checks++;
            if (mem_rd.rd_burst_req !== 1'b0)
              $display("FAIL req_clear_on_valid got=%b exp=0", mem_rd.rd_burst_req);
            else n_pass++;
          end
        end
        mem_rd.rd_burst_data_valid = 1'b0;
        if (!merge_last || blen == 0) begin
          mem_rd.rd_burst_finish = 1'b1;
          @(negedge mem_clk);
        end
        mem_rd.rd_burst_finish = 1'b0;
      end
    end
  end

  // Push the expected bursts, raise read_req and hold it until acknowledged.
  task automatic start_frame(input logic [1:0] idx, input logic [ADDR_BITS-1:0] len,
                             input logic [ADDR_BITS-1:0] base, input bit chk_lat);
    logic [ADDR_BITS-1:0] a, rem;
    burst_t b;
    int cyc;
    bit got;
    a = base;
    rem = len;
    while (rem != 0) begin
      b.addr = a;
      b.len  = (rem > ADDR_BITS'(BURST_SIZE)) ? BURST_BITS'(BURST_SIZE) : rem[BURST_BITS-1:0];
      sb_q.push_back(b);
      a   = a + ADDR_BITS'(b.len);
      rem = rem - ADDR_BITS'(b.len);
    end
    read_addr_index = idx;
    read_len        = len;
    read_req        = 1'b1;
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge mem_clk);
      cyc++;
      if (read_req_ack === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) $display("FAIL ack_timeout got=%b exp=1 after %0d cycles", read_req_ack, cyc);
    else n_pass++;
    if (chk_lat) begin
      n_checks++;
      if (cyc != 3) $display("FAIL ack_latency got=%0d exp=3", cyc);
      else n_pass++;
    end
    n_checks++;
    if (fifo_aclr !== 1'b1) $display("FAIL aclr_with_ack got=%b exp=1", fifo_aclr);
    else n_pass++;
    read_req = 1'b0;
  endtask

  task automatic wait_finish(input int f0);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge mem_clk);
      if (n_finish > f0) got = 1'b1;
    end
    n_checks++;
    if (!got) $display("FAIL finish_timeout got=%0d exp>%0d", n_finish, f0);
    else n_pass++;
    repeat (10) @(negedge mem_clk);
  endtask

  task automatic test_reset();
    int r0;
    rst = 1'b1;
    repeat (2) @(negedge mem_clk);
    n_checks++;
    if (mem_rd.rd_burst_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", mem_rd.rd_burst_req);
    else n_pass++;
    n_checks++;
    if (mem_rd.rd_burst_len !== '0) $display("FAIL rst_len got=%h exp=0", mem_rd.rd_burst_len);
    else n_pass++;
    n_checks++;
    if (mem_rd.rd_burst_addr !== '0) $display("FAIL rst_addr got=%h exp=0", mem_rd.rd_burst_addr);
    else n_pass++;
    n_checks++;
    if (read_req_ack !== 1'b0) $display("FAIL rst_ack got=%b exp=0", read_req_ack);
    else n_pass++;
    n_checks++;
    if (read_finish !== 1'b0) $display("FAIL rst_finish got=%b exp=0", read_finish);
    else n_pass++;
    n_checks++;
    if (fifo_aclr !== 1'b0) $display("FAIL rst_aclr got=%b exp=0", fifo_aclr);
    else n_pass++;
    rst = 1'b0;
    r0 = n_req;
    repeat (100) @(negedge mem_clk);
    n_checks++;
    if (n_req != r0 || read_finish !== 1'b0)
      $display("FAIL idle_quiet reqs=%0d exp=0 finish=%b", n_req - r0, read_finish);
    else n_pass++;
  endtask

  task automatic test_normal_frame();
    int f0;
    f0 = n_finish;
    start_frame(2'd2, 23'd1024, 23'h001000, 1'b1);
    wait_finish(f0);
    n_checks++;
    if (n_finish - f0 != 1) $display("FAIL normal_finish_count got=%0d exp=1", n_finish - f0);
    else n_pass++;
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL normal_bursts_left got=%0d exp=0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_short_tail();
    int f0;
    f0 = n_finish;
    merge_last = 1'b1;
    start_frame(2'd1, 23'd600, 23'h002000, 1'b1);
    wait_finish(f0);
    merge_last = 1'b0;
    n_checks++;
    if (n_finish - f0 != 1) $display("FAIL tail_finish_count got=%0d exp=1", n_finish - f0);
    else n_pass++;
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL tail_bursts_left got=%0d exp=0", sb_q.size());
    else n_pass++;
    n_checks++;
    if (mem_rd.rd_burst_addr !== 23'h002258)
      $display("FAIL tail_end_addr got=%h exp=002258", mem_rd.rd_burst_addr);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int f0, r0;
    f0 = n_finish;
    wr_data_count = 16'd800;
    start_frame(2'd0, 23'd256, 23'h000800, 1'b1);
    r0 = n_req;
    repeat (20) @(negedge mem_clk);
    n_checks++;
    if (n_req != r0) $display("FAIL bp_800_blocked reqs=%0d exp=0", n_req - r0);
    else n_pass++;
    wr_data_count = 16'd769;
    repeat (10) @(negedge mem_clk);
    n_checks++;
    if (n_req != r0) $display("FAIL bp_769_blocked reqs=%0d exp=0", n_req - r0);
    else n_pass++;
    wr_data_count = 16'd768;
    @(negedge mem_clk);
    n_checks++;
    if (mem_rd.rd_burst_req !== 1'b1) $display("FAIL bp_768_req got=%b exp=1", mem_rd.rd_burst_req);
    else n_pass++;
    wait_finish(f0);
    wr_data_count = 16'd0;
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL bp_bursts_left got=%0d exp=0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_restart();
    int f0, s0;
    bit got;
    f0 = n_finish;
    s0 = served;
    start_frame(2'd2, 23'd1024, 23'h001000, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge mem_clk);
      if (served - s0 >= 2) got = 1'b1;
    end
    n_checks++;
    if (!got) $display("FAIL restart_burst2_timeout got=%0d exp=2", served - s0);
    else n_pass++;
    // Bursts 3 and 4 of the first frame must never be requested.
    sb_q.delete();
    start_frame(2'd3, 23'd300, 23'h7FFF80, 1'b0);
    n_checks++;
    if (n_finish != f0) $display("FAIL restart_aborted_finish got=%0d exp=0", n_finish - f0);
    else n_pass++;
    wait_finish(f0);
    n_checks++;
    if (n_finish - f0 != 1) $display("FAIL restart_finish_count got=%0d exp=1", n_finish - f0);
    else n_pass++;
    n_checks++;
    if (served - s0 != 4) $display("FAIL restart_burst_count got=%0d exp=4", served - s0);
    else n_pass++;
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL restart_bursts_left got=%0d exp=0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_zero_len();
    int f0, r0;
    f0 = n_finish;
    r0 = n_req;
    start_frame(2'd0, 23'd0, 23'h000800, 1'b1);
    wait_finish(f0);
    n_checks++;
    if (n_req != r0) $display("FAIL zero_no_req got=%0d exp=0", n_req - r0);
    else n_pass++;
    n_checks++;
    if (n_finish - f0 != 1) $display("FAIL zero_finish_count got=%0d exp=1", n_finish - f0);
    else n_pass++;
  endtask

  initial begin
    rst             = 1'b1;
    read_req        = 1'b0;
    read_addr_0     = 23'h000800;
    read_addr_1     = 23'h002000;
    read_addr_2     = 23'h001000;
    read_addr_3     = 23'h7FFF80;
    read_addr_index = 2'd0;
    read_len        = '0;
    wr_data_count   = 16'd0;

    test_reset();
    test_normal_frame();
    test_short_tail();
    test_backpressure();
    test_restart();
    test_zero_len();

    n_checks++;
    if (n_aclr_bad != 0) $display("FAIL aclr_pairing violations=%0d exp=0", n_aclr_bad);
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
